// File: rtl/i2s_pkg.sv
// Shared constants for the I2S DAC transmitter: serial mode encoding and frame length helper.
package i2s_pkg;

    localparam logic MODE_LJ  = 1'b0;
    localparam logic MODE_I2S = 1'b1;

    function automatic int unsigned frame_bits(input int unsigned slot_width);
        return 2 * slot_width;
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Stereo-pair sample FIFO: synchronous push/pop, combinational head, full/empty flags.
module i2s_sample_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S / left-justified DAC transmitter with stereo FIFO and underrun detection.
// Optional UNDERRUN_CNT output enabled by defining I2S_DAC_TX_UNDERRUN_CNT_EN.
module i2s_dac_tx #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned SLOT_WIDTH   = 32,
    parameter int unsigned BCLK_DIV     = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    S_VALID,
    output logic                    S_READY,
    input  logic [SAMPLE_WIDTH-1:0] S_LEFT,
    input  logic [SAMPLE_WIDTH-1:0] S_RIGHT,
    input  logic                    MODE_I2S,
    output logic                    AUD_XCK,
    output logic                    AUD_BCLK,
    output logic                    AUD_DACLRCK,
    output logic                    AUD_DACDAT,
    output logic                    UNDERRUN
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]             UNDERRUN_CNT
`endif
);

    import i2s_pkg::*;

    localparam int unsigned FRAME_BITS = frame_bits(SLOT_WIDTH);
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
    localparam int unsigned DIV_W      = $clog2(BCLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_WIDTH);
    localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(SAMPLE_WIDTH);

    logic [DIV_W-1:0]        div_q, div_d;
    logic [CNT_W-1:0]        bit_q, bit_d;
    logic                    started_q, bclk_q, lrck_q, dat_q, underrun_q, ready_q, mode_q;
    logic [SAMPLE_WIDTH-1:0] frame_l_q, frame_r_q;

    logic                      bclk_fall, frame_start, underrun_d, dat_d, right_slot, cur_mode;
    logic [CNT_W-1:0]          slot_pos, msb_pos, off;
    logic [SAMPLE_WIDTH-1:0]   cur_l, cur_r, cur_sample, shifted;
    logic [2*SAMPLE_WIDTH-1:0] fifo_rdata;
    logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;

    assign fifo_push = S_VALID && S_READY;
    assign fifo_pop  = frame_start && !fifo_empty;

    i2s_sample_fifo #(
        .WIDTH (2 * SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (fifo_push),
        .wdata ({S_LEFT, S_RIGHT}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        bclk_fall   = (div_q == DIV_LAST);
        div_d       = bclk_fall ? '0 : div_q + 1'b1;
        // The very first fall after reset opens a frame without waiting for a wrap.
        frame_start = bclk_fall && (!started_q || bit_q == BIT_LAST);
        bit_d       = bit_q;
        if (frame_start)    bit_d = '0;
        else if (bclk_fall) bit_d = bit_q + 1'b1;
        underrun_d  = frame_start && fifo_empty;

        cur_l    = frame_l_q;
        cur_r    = frame_r_q;
        cur_mode = mode_q;
        if (frame_start) begin
            cur_l    = fifo_empty ? '0 : fifo_rdata[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
            cur_r    = fifo_empty ? '0 : fifo_rdata[SAMPLE_WIDTH-1:0];
            cur_mode = MODE_I2S;
        end

        right_slot = (bit_d >= SLOT_C);
        slot_pos   = right_slot ? bit_d - SLOT_C : bit_d;
        msb_pos    = (cur_mode == i2s_pkg::MODE_I2S) ? CNT_W'(1) : '0;
        off        = slot_pos - msb_pos;
        cur_sample = right_slot ? cur_r : cur_l;
        shifted    = cur_sample << off;
        dat_d      = (slot_pos >= msb_pos) && (off < SAMPLE_C) && shifted[SAMPLE_WIDTH-1];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_q      <= '0;
            bit_q      <= '0;
            started_q  <= 1'b0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            dat_q      <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
            mode_q     <= 1'b0;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
        end else begin
            div_q      <= div_d;
            bit_q      <= bit_d;
            bclk_q     <= (div_d >= DIV_HALF);
            underrun_q <= underrun_d;
            ready_q    <= 1'b1;
            if (bclk_fall) begin
                lrck_q <= right_slot;
                dat_q  <= dat_d;
            end
            if (frame_start) begin
                started_q <= 1'b1;
                mode_q    <= cur_mode;
                frame_l_q <= cur_l;
                frame_r_q <= cur_r;
            end
        end
    end

`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
    logic [15:0] und_cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            und_cnt_q <= '0;
        end else if (underrun_d && und_cnt_q != 16'hFFFF) begin
            und_cnt_q <= und_cnt_q + 16'd1;
        end
    end

    assign UNDERRUN_CNT = und_cnt_q;
`endif

    assign AUD_XCK     = CLK;
    assign AUD_BCLK    = bclk_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;
    assign UNDERRUN    = underrun_q;
    assign S_READY     = ready_q && !fifo_full;

endmodule
